hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/cpu_types_pkg.sv | 28 ++
 rtl/hazard_unit_if.sv | 50 +++++
 rtl/hazard_unit.sv | 113 +++++++++++
 tb/tb_hazard_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index, data word, hazard FSM state, hazard control bundle.
package cpu_types_pkg;
    localparam int REG_W  = 5;
    localparam int WORD_W = 32;

    typedef logic [REG_W-1:0]  regbits_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOADUSE = 2'd1,
        DWAIT   = 2'd2,
        HALTED  = 2'd3
    } hazard_state_t;

    // Pipeline control outputs, MSB first in the order they appear on the interface.
    typedef struct packed {
        logic pc_en;
        logic stall_ifid;
        logic stall_idex;
        logic stall_exmem;
        logic flush_ifid;
        logic flush_idex;
        logic flush_exmem;
        logic flush_memwb;
        logic halted;
    } hazard_ctl_t;
endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline hazard signals; modport hu is the hazard unit, tb is the pipeline side.
// stall_cycles exists only when HAZARD_PERF_EN is defined.
interface hazard_unit_if;
    import cpu_types_pkg::*;

    regbits_t rs_id;
    regbits_t rt_id;
    regbits_t rw_ex;
    logic     regwrite_ex;
    logic     memread_ex;
    logic     dren_mem;
    logic     dwen_mem;
    logic     dhit;
    logic     ihit;
    logic     pc_redirect_mem;
    logic     halt_wb;

    logic     pc_en;
    logic     stall_ifid;
    logic     stall_idex;
    logic     stall_exmem;
    logic     flush_ifid;
    logic     flush_idex;
    logic     flush_exmem;
    logic     flush_memwb;
    logic     halted;
`ifdef HAZARD_PERF_EN
    word_t    stall_cycles;
`endif

    modport hu (
        input  rs_id, rt_id, rw_ex, regwrite_ex, memread_ex,
        input  dren_mem, dwen_mem, dhit, ihit, pc_redirect_mem, halt_wb,
        output pc_en, stall_ifid, stall_idex, stall_exmem,
        output flush_ifid, flush_idex, flush_exmem, flush_memwb, halted
`ifdef HAZARD_PERF_EN
        , output stall_cycles
`endif
    );

    modport tb (
        output rs_id, rt_id, rw_ex, regwrite_ex, memread_ex,
        output dren_mem, dwen_mem, dhit, ihit, pc_redirect_mem, halt_wb,
        input  pc_en, stall_ifid, stall_idex, stall_exmem,
        input  flush_ifid, flush_idex, flush_exmem, flush_memwb, halted
`ifdef HAZARD_PERF_EN
        , input stall_cycles
`endif
    );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use bubbles, data/instr memory waits, redirect flush, halt.
// Controls are combinational in the cycle of the event; HAZARD_PERF_EN adds stall_cycles.
module hazard_unit #(
    parameter int LU_BUBBLES = 1
) (
    input  logic      CLK,
    input  logic      nRST,
    hazard_unit_if.hu hif
);
    import cpu_types_pkg::*;

    localparam logic [1:0] LU_EXTRA = 2'(LU_BUBBLES - 1);

    hazard_state_t state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    hazard_ctl_t   ctl;
    logic          lu_hazard;
    logic          dmiss;

    assign lu_hazard = hif.memread_ex & hif.regwrite_ex & (hif.rw_ex != '0) &
                       ((hif.rw_ex == hif.rs_id) | (hif.rw_ex == hif.rt_id));
    assign dmiss     = (hif.dren_mem | hif.dwen_mem) & ~hif.dhit;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ctl       = '0;
        ctl.pc_en = 1'b1;
        if (state_q == HALTED) begin
            ctl.pc_en       = 1'b0;
            ctl.stall_ifid  = 1'b1;
            ctl.stall_idex  = 1'b1;
            ctl.stall_exmem = 1'b1;
            ctl.halted      = 1'b1;
        end else begin
            if (dmiss) begin
                // A redirect sitting in MEM stays there, so it flushes on the dhit cycle.
                ctl.pc_en       = 1'b0;
                ctl.stall_ifid  = 1'b1;
                ctl.stall_idex  = 1'b1;
                ctl.stall_exmem = 1'b1;
                ctl.flush_memwb = 1'b1;
                state_d         = DWAIT;
                cnt_d           = '0;
            end else if (hif.pc_redirect_mem) begin
                ctl.flush_ifid  = 1'b1;
                ctl.flush_idex  = 1'b1;
                ctl.flush_exmem = 1'b1;
                state_d         = IDLE;
                cnt_d           = '0;
            end else if (state_q == LOADUSE) begin
                ctl.pc_en       = 1'b0;
                ctl.stall_ifid  = 1'b1;
                ctl.flush_idex  = 1'b1;
                cnt_d           = cnt_q - 2'd1;
                state_d         = (cnt_q == 2'd1) ? IDLE : LOADUSE;
            end else if (lu_hazard) begin
                // The detection cycle is the first bubble; LOADUSE covers the rest.
                ctl.pc_en       = 1'b0;
                ctl.stall_ifid  = 1'b1;
                ctl.flush_idex  = 1'b1;
                cnt_d           = LU_EXTRA;
                state_d         = (LU_EXTRA == 2'd0) ? IDLE : LOADUSE;
            end else begin
                state_d = IDLE;
                if (!hif.ihit) begin
                    ctl.pc_en      = 1'b0;
                    ctl.flush_ifid = 1'b1;
                end
            end
            if (hif.halt_wb) begin
                state_d = HALTED;
            end
        end
        if (!nRST) begin
            ctl = '0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hif.pc_en       = ctl.pc_en;
    assign hif.stall_ifid  = ctl.stall_ifid;
    assign hif.stall_idex  = ctl.stall_idex;
    assign hif.stall_exmem = ctl.stall_exmem;
    assign hif.flush_ifid  = ctl.flush_ifid;
    assign hif.flush_idex  = ctl.flush_idex;
    assign hif.flush_exmem = ctl.flush_exmem;
    assign hif.flush_memwb = ctl.flush_memwb;
    assign hif.halted      = ctl.halted;

`ifdef HAZARD_PERF_EN
    word_t stall_cycles_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cycles_q <= '0;
        end else if (!ctl.pc_en && (stall_cycles_q != '1)) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
        end
    end

    assign hif.stall_cycles = stall_cycles_q;
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit with LU_BUBBLES=1.
module tb_hazard_unit;
    import cpu_types_pkg::*;

    logic CLK;
    logic nRST;
    int   vectors     = 0;
    int   miscompares = 0;

    hazard_unit_if hif ();

    hazard_unit #(.LU_BUBBLES(1)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .hif  (hif)
    );

    // {pc_en, stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex, flush_exmem, flush_memwb, halted}
    localparam logic [8:0] O_RST   = 9'b0_000_0000_0;
    localparam logic [8:0] O_IDLE  = 9'b1_000_0000_0;
    localparam logic [8:0] O_LU    = 9'b0_100_0100_0;
    localparam logic [8:0] O_DWAIT = 9'b0_111_0001_0;
    localparam logic [8:0] O_REDIR = 9'b1_000_1110_0;
    localparam logic [8:0] O_IMEM  = 9'b0_000_1000_0;
    localparam logic [8:0] O_HALT  = 9'b0_111_0000_1;

    logic [8:0] outs;
    assign outs = {hif.pc_en, hif.stall_ifid, hif.stall_idex, hif.stall_exmem,
                   hif.flush_ifid, hif.flush_idex, hif.flush_exmem, hif.flush_memwb, hif.halted};

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic quiet;
        hif.rs_id           = 5'd0;
        hif.rt_id           = 5'd0;
        hif.rw_ex           = 5'd0;
        hif.regwrite_ex     = 1'b0;
        hif.memread_ex      = 1'b0;
        hif.dren_mem        = 1'b0;
        hif.dwen_mem        = 1'b0;
        hif.dhit            = 1'b1;
        hif.ihit            = 1'b1;
        hif.pc_redirect_mem = 1'b0;
        hif.halt_wb         = 1'b0;
    endtask

    task automatic set_load(input logic [4:0] rw, input logic [4:0] rs, input logic [4:0] rt);
        hif.memread_ex  = 1'b1;
        hif.regwrite_ex = 1'b1;
        hif.rw_ex       = rw;
        hif.rs_id       = rs;
        hif.rt_id       = rt;
    endtask

    initial begin
        nRST = 1'b0;
        quiet();
        #1;
        chk("reset_outputs", 32'(outs), 32'(O_RST));
`ifdef HAZARD_PERF_EN
        chk("reset_stall_cycles", hif.stall_cycles, 32'd0);
`endif
        tick(); tick();
        nRST = 1'b1;
        #1;
        chk("idle_after_reset", 32'(outs), 32'(O_IDLE));

        // Load-use on rs, one bubble then clear
        set_load(5'd8, 5'd8, 5'd3);
        #1; chk("lu_rs_bubble", 32'(outs), 32'(O_LU));
        tick(); quiet();
        #1; chk("lu_rs_release", 32'(outs), 32'(O_IDLE));
        tick();
        #1; chk("lu_rs_still_idle", 32'(outs), 32'(O_IDLE));

        set_load(5'd12, 5'd4, 5'd12);
        #1; chk("lu_rt_bubble", 32'(outs), 32'(O_LU));
        tick(); quiet();
        #1; chk("lu_rt_release", 32'(outs), 32'(O_IDLE));

        set_load(5'd0, 5'd0, 5'd0);
        #1; chk("lu_reg0_none", 32'(outs), 32'(O_IDLE));
        tick();
        #1; chk("lu_reg0_next", 32'(outs), 32'(O_IDLE));
        hif.regwrite_ex = 1'b0; hif.rw_ex = 5'd9; hif.rs_id = 5'd9;
        #1; chk("lu_no_regwrite", 32'(outs), 32'(O_IDLE));
        quiet();
        set_load(5'd9, 5'd1, 5'd2);
        #1; chk("lu_no_match", 32'(outs), 32'(O_IDLE));
        quiet();

        hif.ihit = 1'b0;
        #1; chk("imem_wait", 32'(outs), 32'(O_IMEM));
        set_load(5'd5, 5'd5, 5'd0);
        #1; chk("lu_over_imem", 32'(outs), 32'(O_LU));
        tick(); quiet();
        #1; chk("imem_lu_release", 32'(outs), 32'(O_IDLE));

        hif.pc_redirect_mem = 1'b1;
        #1; chk("redirect_flush", 32'(outs), 32'(O_REDIR));
        set_load(5'd7, 5'd7, 5'd7);
        hif.ihit = 1'b0;
        #1; chk("redirect_over_lu", 32'(outs), 32'(O_REDIR));
        tick(); quiet();
        #1; chk("redirect_one_cycle", 32'(outs), 32'(O_IDLE));

        // Reset in the middle of a data wait
        hif.dren_mem = 1'b1; hif.dhit = 1'b0;
        #1; chk("rst_dwait_enter", 32'(outs), 32'(O_DWAIT));
        tick();
        #1; chk("rst_dwait_hold", 32'(outs), 32'(O_DWAIT));
        nRST = 1'b0;
        #1; chk("rst_mid_dwait", 32'(outs), 32'(O_RST));
`ifdef HAZARD_PERF_EN
        chk("rst_mid_stall_cycles", hif.stall_cycles, 32'd0);
`endif
        quiet();
        tick();
        nRST = 1'b1;
        #1; chk("rst_release_idle", 32'(outs), 32'(O_IDLE));

        // Three miss cycles then dhit
        hif.dren_mem = 1'b1; hif.dhit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1; chk($sformatf("dmiss_cycle%0d", i), 32'(outs), 32'(O_DWAIT));
            tick();
        end
        hif.dhit = 1'b1;
        #1; chk("dmiss_dhit_release", 32'(outs), 32'(O_IDLE));
        tick(); quiet();
        #1; chk("dmiss_after", 32'(outs), 32'(O_IDLE));
`ifdef HAZARD_PERF_EN
        chk("dmiss_stall_cycles", hif.stall_cycles, 32'd3);
`endif

        // Miss with a redirect held in MEM
        hif.dwen_mem = 1'b1; hif.dhit = 1'b0; hif.pc_redirect_mem = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1; chk($sformatf("miss_redir_wait%0d", i), 32'(outs), 32'(O_DWAIT));
            tick();
        end
        hif.dhit = 1'b1;
        #1; chk("miss_redir_dhit", 32'(outs), 32'(O_REDIR));
        tick(); quiet();
        #1; chk("miss_redir_after", 32'(outs), 32'(O_IDLE));

        set_load(5'd3, 5'd3, 5'd0);
        hif.dren_mem = 1'b1; hif.dhit = 1'b0;
        #1; chk("dwait_over_lu", 32'(outs), 32'(O_DWAIT));
        tick(); quiet();
        #1; chk("dwait_lu_after", 32'(outs), 32'(O_IDLE));

        // Halt is sticky until reset
        hif.halt_wb = 1'b1;
        tick();
        hif.halt_wb = 1'b0;
        #1; chk("halt_entered", 32'(outs), 32'(O_HALT));
        set_load(5'd6, 5'd6, 5'd6);
        hif.pc_redirect_mem = 1'b1; hif.dren_mem = 1'b1; hif.dhit = 1'b0;
        tick(); tick();
        #1; chk("halt_sticky", 32'(outs), 32'(O_HALT));
        quiet();
        tick();
        #1; chk("halt_sticky_quiet", 32'(outs), 32'(O_HALT));
        nRST = 1'b0;
        #1; chk("halt_reset", 32'(outs), 32'(O_RST));
        tick();
        nRST = 1'b1;
        #1; chk("halt_reset_idle", 32'(outs), 32'(O_IDLE));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
